// File: rtl/lfsr5b_checker.sv
// Checker for a 5-bit Galois LFSR stream (x^5+x^2+1).
// Locks onto the stream, then flywheels a local prediction to count corrupted or skipped samples.
module lfsr5b_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [4:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             zero_seen
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  localparam logic [3:0]       LockCnt4 = 4'(LOCK_CNT);
  localparam logic [3:0]       LossCnt4 = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ErrOne   = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [4:0]       pred_q;
  logic [3:0]       match_cnt_q;
  logic [3:0]       miss_cnt_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             zero_seen_q;

  function automatic logic [4:0] step(input logic [4:0] s);
    return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
  endfunction

  logic       data_zero;
  logic       data_hit;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;

  always_comb begin
    data_zero = (in_data == 5'd0);
    data_hit  = (in_data == pred_q);
    match_inc = match_cnt_q + 4'd1;
    miss_inc  = miss_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StSearch;
      pred_q      <= 5'b11111;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      zero_seen_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      if (in_valid) begin
        if (data_zero) zero_seen_q <= 1'b1;
        unique case (state_q)
          StSearch: begin
            if (!data_zero) begin
              pred_q      <= step(in_data);
              match_cnt_q <= 4'd1;
              state_q     <= StVerify;
            end
          end
          StVerify: begin
            if (data_zero) begin
              match_cnt_q <= 4'd0;
              state_q     <= StSearch;
            end else if (data_hit) begin
              pred_q      <= step(in_data);
              match_cnt_q <= match_inc;
              if (match_inc == LockCnt4) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end else begin
              pred_q      <= step(in_data);
              match_cnt_q <= 4'd1;
            end
          end
          StLocked: begin
            // Flywheel: never reseed from the incoming data while locked.
            pred_q <= step(pred_q);
            if (data_hit) begin
              miss_cnt_q <= 4'd0;
            end else begin
              err_pulse_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ErrOne;
              miss_cnt_q <= miss_inc;
              if (miss_inc == LossCnt4) begin
                state_q     <= StSearch;
                locked_q    <= 1'b0;
                miss_cnt_q  <= 4'd0;
                match_cnt_q <= 4'd0;
              end
            end
          end
          default: state_q <= StSearch;
        endcase
      end
      // Placed last so a clear overrides a same-edge increment.
      if (clr_err) err_cnt_q <= '0;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_lfsr5b_checker.sv
// Bench for lfsr5b_checker: two instances (default and ERR_W=2/LOSS_CNT=15) driven by the same
// stream and compared every cycle against a sequence-level model, plus directed checks.
module tb_lfsr5b_checker;

  logic       clk;
  logic       rst_b;
  logic       in_valid;
  logic [4:0] in_data;
  logic       clr_err;

  logic       lk1, ep1, zs1;
  logic [7:0] ec1;
  logic       lk2, ep2, zs2;
  logic [1:0] ec2;

  int n_cmp;
  int n_err;

  lfsr5b_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) u_dut1 (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_err   (clr_err),
    .locked    (lk1),
    .err_pulse (ep1),
    .err_cnt   (ec1),
    .zero_seen (zs1)
  );

  lfsr5b_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(2)) u_dut2 (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_err   (clr_err),
    .locked    (lk2),
    .err_pulse (ep2),
    .err_cnt   (ec2),
    .zero_seen (zs2)
  );

  always #5 clk = ~clk;

  // Multiply by x modulo x^5+x^2+1.
  function automatic logic [4:0] lf_next(input logic [4:0] s);
    logic [5:0] t;
    t = {s, 1'b0};
    if (t[5]) t = t ^ 6'b100101;
    return t[4:0];
  endfunction

  typedef struct {
    int         mode;   // 0 hunting, 1 confirming, 2 tracking
    logic [4:0] expect_v;
    int         run;
    int         misses;
    int         errs;
    bit         pulse;
    bit         lk;
    bit         zero;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.expect_v = 5'b11111; r.run = 0; r.misses = 0;
    r.errs = 0; r.pulse = 0; r.lk = 0; r.zero = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit v, input logic [4:0] d, input bit c,
                                    input int lock_n, input int loss_n, input int err_max);
    mdl_t r;
    r = m;
    r.pulse = 0;
    if (v) begin
      if (d == 0) r.zero = 1;
      if (m.mode == 0) begin
        if (d != 0) begin r.mode = 1; r.run = 1; r.expect_v = lf_next(d); end
      end else if (m.mode == 1) begin
        if (d == 0) begin
          r.mode = 0; r.run = 0;
        end else begin
          r.run = (d == m.expect_v) ? m.run + 1 : 1;
          r.expect_v = lf_next(d);
          if (r.run == lock_n) begin r.mode = 2; r.lk = 1; end
        end
      end else begin
        r.expect_v = lf_next(m.expect_v);
        if (d == m.expect_v) begin
          r.misses = 0;
        end else begin
          r.pulse  = 1;
          r.errs   = (m.errs + 1 > err_max) ? err_max : m.errs + 1;
          r.misses = m.misses + 1;
          if (r.misses == loss_n) begin
            r.mode = 0; r.lk = 0; r.misses = 0; r.run = 0;
          end
        end
      end
    end
    if (c) r.errs = 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".d1.locked"},    32'(lk1), 32'(m1.lk));
    chk({tag, ".d1.err_pulse"}, 32'(ep1), 32'(m1.pulse));
    chk({tag, ".d1.err_cnt"},   32'(ec1), 32'(m1.errs));
    chk({tag, ".d1.zero_seen"}, 32'(zs1), 32'(m1.zero));
    chk({tag, ".d2.locked"},    32'(lk2), 32'(m2.lk));
    chk({tag, ".d2.err_pulse"}, 32'(ep2), 32'(m2.pulse));
    chk({tag, ".d2.err_cnt"},   32'(ec2), 32'(m2.errs));
    chk({tag, ".d2.zero_seen"}, 32'(zs2), 32'(m2.zero));
  endtask

  logic [4:0] truth;

  task automatic drive(input bit v, input logic [4:0] d, input bit c, input string tag);
    in_valid = v;
    in_data  = d;
    clr_err  = c;
    @(posedge clk);
    m1 = mdl_step(m1, v, d, c, 4, 3, 255);
    m2 = mdl_step(m2, v, d, c, 4, 15, 3);
    #1;
    chk_all(tag);
  endtask

  task automatic good(input string tag);
    drive(1'b1, truth, 1'b0, tag);
    truth = lf_next(truth);
  endtask

  task automatic bad(input bit c, input string tag);
    logic [4:0] d;
    d = truth ^ 5'($urandom_range(1, 31));
    drive(1'b1, d, c, tag);
    truth = lf_next(truth);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clk = 1'b0; rst_b = 1'b0;
    in_valid = 1'b0; in_data = 5'd0; clr_err = 1'b0;
    truth = 5'b11111;
    m1 = mdl_reset(); m2 = mdl_reset();
    #12;
    chk_all("reset");
    chk("reset.locked", 32'(lk1), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Initial lock on the reset-seed sequence.
    for (int i = 0; i < 4; i++) good("lockup");
    chk("lock4.locked", 32'(lk1), 32'd1);
    chk("lock4.err_cnt", 32'(ec1), 32'd0);
    chk("lock4.next_is_00110", 32'(truth), 32'(5'b00110));

    // Single corrupted value, flywheel keeps alignment.
    drive(1'b1, 5'b00111, 1'b0, "single_bad");
    truth = lf_next(truth);
    chk("single_bad.pulse", 32'(ep1), 32'd1);
    chk("single_bad.err_cnt", 32'(ec1), 32'd1);
    for (int i = 0; i < 3; i++) good("resume");
    chk("resume.locked", 32'(lk1), 32'd1);
    chk("resume.err_cnt", 32'(ec1), 32'd1);

    // Three consecutive misses drop lock on the default instance only.
    for (int i = 0; i < 3; i++) bad(1'b0, "loss");
    chk("loss.d1.locked", 32'(lk1), 32'd0);
    chk("loss.d1.err_cnt", 32'(ec1), 32'd4);
    chk("loss.d2.locked", 32'(lk2), 32'd1);
    chk("loss.d2.err_cnt", 32'(ec2), 32'd3);
    for (int i = 0; i < 4; i++) good("relock");
    chk("relock.locked", 32'(lk1), 32'd1);

    // Valid gap while locked.
    for (int i = 0; i < 5; i++) drive(1'b0, 5'($urandom), 1'b0, "gap");
    good("after_gap");
    chk("after_gap.pulse", 32'(ep1), 32'd0);
    chk("after_gap.locked", 32'(lk1), 32'd1);

    // Asynchronous reset between edges.
    #2;
    rst_b = 1'b0;
    #1;
    m1 = mdl_reset(); m2 = mdl_reset();
    chk_all("async_rst");
    chk("async_rst.err_cnt", 32'(ec1), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    truth = 5'b11111;

    // Zero samples while hunting.
    drive(1'b1, 5'b00000, 1'b0, "zero1");
    drive(1'b1, 5'b11011, 1'b0, "zero_mid");
    drive(1'b1, 5'b00000, 1'b0, "zero2");
    chk("zero.zero_seen", 32'(zs1), 32'd1);
    chk("zero.locked", 32'(lk1), 32'd0);
    for (int i = 0; i < 4; i++) good("lock_after_zero");
    chk("lock_after_zero.locked", 32'(lk1), 32'd1);
    chk("lock_after_zero.zero_seen", 32'(zs1), 32'd1);

    // Saturation on the narrow counter, then clear against a same-edge miss.
    for (int i = 0; i < 6; i++) bad(1'b0, "sat");
    chk("sat.d2.err_cnt", 32'(ec2), 32'd3);
    chk("sat.d2.locked", 32'(lk2), 32'd1);
    bad(1'b1, "clr_vs_inc");
    chk("clr_vs_inc.d2.err_cnt", 32'(ec2), 32'd0);
    chk("clr_vs_inc.d2.pulse", 32'(ep2), 32'd1);

    // Randomized mix of clean, corrupted, zero and idle cycles.
    for (int i = 0; i < 400; i++) begin
      bit         v;
      int         r;
      logic [4:0] d;
      v = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 19);
      if (r < 16) d = truth;
      else if (r == 16) d = 5'd0;
      else d = 5'($urandom);
      drive(v, d, ($urandom_range(0, 49) == 0), "random");
      if (v) truth = lf_next(truth);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr5b_checker.md
Name: lfsr5b_checker

Overview:
- Downstream consumer of the 5-bit Galois LFSR (polynomial x^5+x^2+1, reset seed 5'b11111), fed from its q[4:0] output.
- Self-synchronises to the incoming pseudo-random stream, then flywheels a local prediction to detect corrupted or skipped values.
- Reports lock status, a per-error pulse, a saturating error count and a sticky illegal-zero flag.
- Used as the checker half of a BIST / PRBS loopback path.

Parameters:
- LOCK_CNT, 4: consecutive consistent samples, seed included, required to declare lock; legal range 2..15.
- LOSS_CNT, 3: consecutive mismatches while locked that drop lock; legal range 1..15.
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_b  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is a new LFSR sample this cycle.
- in_data  input  5  LFSR sample; bit 4 is the MSB.
- clr_err  input  1  synchronous clear of err_cnt.
- locked  output  1  registered; high while in LOCKED.
- err_pulse  output  1  registered; one-cycle pulse per mismatch detected in LOCKED.
- err_cnt  output  ERR_W  registered; saturating mismatch count.
- zero_seen  output  1  registered, sticky; in_data==0 was accepted at least once.

Behaviour:
- step(s) is the LFSR next-state function:
  - n[0]=s[4]
  - n[1]=s[0]
  - n[2]=s[1]^s[4]
  - n[3]=s[2]
  - n[4]=s[3]
- Sequence from reset seed: 11111 -> 11011 -> 10011 -> 00011 -> 00110. Period 31; 00000 is the lock-up state and is never legal.
- Internal registers: state (SEARCH / VERIFY / LOCKED), pred[4:0], match_cnt[3:0], miss_cnt[3:0].
- Reset (asynchronous, rst_b=0) forces: state=SEARCH, pred=5'b11111, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_cnt=0, zero_seen=0.
- A cycle with in_valid=0 changes nothing except err_pulse, which is forced to 0, and err_cnt, which is still cleared by clr_err.
- Any accepted sample with in_data==0 sets zero_seen, which stays set until reset.
- SEARCH:
  - Valid nonzero sample: pred<=step(in_data), match_cnt<=1, go to VERIFY.
  - Valid zero sample: stay in SEARCH.
- VERIFY:
  - in_data==pred: match_cnt+1. If the new count equals LOCK_CNT, go to LOCKED and set locked=1 on the same edge. pred<=step(in_data).
  - in_data!=pred and nonzero: reseed with pred<=step(in_data), match_cnt<=1, stay in VERIFY.
  - in_data==0: go to SEARCH, match_cnt<=0.
- LOCKED:
  - The block flywheels: pred<=step(pred) on every valid sample and never reseeds from in_data.
  - Match: miss_cnt<=0, err_pulse<=0.
  - Mismatch, including in_data==0: err_pulse<=1, err_cnt<=err_cnt+1 saturating at all-ones, miss_cnt+1.
  - If the new miss_cnt equals LOSS_CNT: go to SEARCH, locked<=0, miss_cnt<=0, match_cnt<=0. That final mismatch still pulses and counts.
- err_pulse and err_cnt update on the same edge that accepts the bad sample, giving 1-cycle latency from in_data.
- clr_err=1 clears err_cnt on that edge and wins over a simultaneous increment, so the result is 0. clr_err does not affect lock state or zero_seen.
- err_cnt holds at 2^ERR_W-1; no wrap-around.
- Reset asserted mid-operation aborts immediately; outputs go to reset values without waiting for clk.
- Outputs have no combinational path from any input.

Test Plan:
- Reset, then feed 11111, 11011, 10011, 00011 with in_valid=1 every cycle -> locked rises on the 4th accepted edge; err_cnt=0, err_pulse never asserts.
- While locked, replace one expected 00110 with 00111, then resume the correct sequence -> one err_pulse cycle, err_cnt=1, locked stays 1, later samples match because prediction continued from 00110.
- While locked, send 3 consecutive wrong values -> err_cnt=3, locked falls on the 3rd bad edge; a fresh correct 4-sample run relocks.
- In SEARCH, send 00000, then 11011, 00000 -> zero_seen=1 permanently; state returns to SEARCH after the second zero; locked never asserts.
- With ERR_W=2 and LOSS_CNT=15, send 6 mismatches while locked -> err_cnt saturates at 3. Assert clr_err together with a 7th mismatch -> err_cnt=0, err_pulse=1.
- Gap in_valid=0 for 5 cycles mid-stream while locked -> no state change; the next valid expected value matches; dropping rst_b between edges clears all outputs asynchronously.
